fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), meaning the instruction driven on inst_ID when the IF/ID register is empty or flushed.
REQ-003 SHALL have one clock and asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-004 PC_EN_IF  in  1  hazard-unit PC enable; reg_FD_EN  in  1  IF/ID enable; reg_FD_stall  in  1  IF/ID hold; reg_FD_flush  in  1  IF/ID flush / redirect.
REQ-005 branch_target_ID  in  32  redirect PC, valid when reg_FD_flush=1.
REQ-006 imem_req  out  1  fetch request; imem_addr  out  32  fetch address; imem_ready  in  1  response valid this cycle; imem_rdata  in  32  instruction word.
REQ-007 PC_ID  out  32  IF/ID PC; inst_ID  out  32  IF/ID instruction; valid_ID  out  1  IF/ID holds a real instruction.

Function
REQ-008 advance = PC_EN_IF & reg_FD_EN & ~reg_FD_stall; the block SHALL compute it combinationally each cycle.
REQ-009 SHALL implement FSM states REQ (request outstanding), HOLD (word buffered, ID stalled), DROP (discarding stale response).
REQ-010 REQ: imem_req=1, imem_addr=req_addr; imem_addr SHALL stay constant until the cycle imem_ready=1.
REQ-011 REQ, imem_ready=1, advance=1, no flush: IF/ID <= {req_addr, imem_rdata, valid=1}; PC <= PC+4 (mod 2^32 wrap); stay REQ with the new address next cycle.
REQ-012 REQ, imem_ready=1, advance=0, no flush: word and address SHALL be captured in the skid buffer; IF/ID holds; go HOLD.
REQ-013 HOLD: imem_req=0; when advance=1, the skid buffer SHALL load into IF/ID (valid=1), PC <= PC+4, go REQ.
REQ-014 reg_FD_flush=1 SHALL have priority over stall and advance: IF/ID <= {PC_ID unchanged, NOP_INST, valid=0}; PC <= branch_target_ID; skid buffer cleared.
REQ-015 Flush in REQ with imem_ready=1: response discarded, next state REQ at branch_target_ID.
REQ-016 Flush in REQ with imem_ready=0: go DROP; imem_req stays 1 at the stale address until imem_ready; the response is discarded, then go REQ at the latched target.
REQ-017 Flush in DROP: latched target updated to the newest branch_target_ID; remain DROP.
REQ-018 Flush in HOLD: buffer discarded; go REQ at branch_target_ID next cycle.
REQ-019 With no accepted response, advance=1 and no flush, the IF/ID register SHALL load valid=0, inst_ID=NOP_INST (bubble); with advance=0 it holds.
REQ-020 Fetch-to-ID latency SHALL be one clock after the imem_ready cycle when not stalled.

Reset
REQ-021 On rst: state=REQ, PC=RESET_PC, PC_ID=0, inst_ID=NOP_INST, valid_ID=0, skid buffer empty; imem_req=1 at the first clock after rst deasserts.
REQ-022 Reset asserted mid-request SHALL abandon the request; memory responses in the reset cycle are ignored.

Configuration
REQ-023 Macro FETCH_PERF_EN defined: adds outputs perf_fetch_cnt[31:0] (count of words loaded into IF/ID valid) and perf_stall_cnt[31:0] (cycles in HOLD), both reset to 0 and wrapping at 2^32.
REQ-024 Macro undefined: those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-025 Shared package core_pkg SHALL hold the XLEN=32 constant, the NOP_INST default value and the fetch FSM state encoding.
REQ-026 One sub-module fetch_skid_buffer (1-entry {addr, inst, full} register with load/clear/pop) is natural; the FSM and PC logic live in fetch_stage.

Verification
REQ-027 Reset with RESET_PC=0x100, imem_ready=1 always, advance=1 -> imem_addr 0x100,0x104,0x108; PC_ID follows one cycle later; valid_ID=1.
REQ-028 Response at 0x104 with reg_FD_stall=1 for 3 cycles -> HOLD, imem_req=0 for 3 cycles, then PC_ID=0x104 and inst_ID=rdata; next imem_addr=0x108.
REQ-029 Flush with target 0x200 while imem_ready=0 for 2 cycles -> imem_addr stays at the stale value until ready, the response is discarded, then imem_addr=0x200; valid_ID=0 meanwhile.
REQ-030 Flush and imem_ready in the same cycle in REQ -> no valid IF/ID load; next imem_addr=target.
REQ-031 rst asserted asynchronously mid-HOLD -> outputs reach reset values without a clock edge; perf counters (FETCH_PERF_EN) read 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: data width, the NOP encoding used for bubbles and
// the instruction-fetch FSM state encoding.
package core_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_HOLD = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid register holding a fetched {addr, inst} pair while the
// decode stage is stalled.
module fetch_skid_buffer
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic            pop,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] inst_in,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] inst,
    output logic            full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            inst <= '0;
        end else if (clear || pop) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            addr <= addr_in;
            inst <= inst_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, imem handshake and IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
//
// state | meaning
// ------+----------------------------------------------------------
// REQ   | request outstanding at pc, waiting for imem_ready
// HOLD  | response word parked in the skid buffer, ID stalled
// DROP  | flushed while a request was in flight; discard its response
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PC_EN_IF,
    input  logic            reg_FD_EN,
    input  logic            reg_FD_stall,
    input  logic            reg_FD_flush,
    input  logic [XLEN-1:0] branch_target_ID,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PC_ID,
    output logic [XLEN-1:0] inst_ID,
    output logic            valid_ID
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drop_target;
    logic            advance;
    logic            skid_load;
    logic            skid_pop;
    logic [XLEN-1:0] skid_addr;
    logic [XLEN-1:0] skid_inst;
    logic            skid_full;

    assign advance   = PC_EN_IF & reg_FD_EN & ~reg_FD_stall;
    assign imem_addr = pc;
    assign skid_load = (state == FETCH_REQ) & imem_ready & ~advance & ~reg_FD_flush;
    assign skid_pop  = (state == FETCH_HOLD) & advance & ~reg_FD_flush;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (reg_FD_flush),
        .pop     (skid_pop),
        .addr_in (pc),
        .inst_in (imem_rdata),
        .addr    (skid_addr),
        .inst    (skid_inst),
        .full    (skid_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH_REQ;
            pc          <= RESET_PC;
            drop_target <= RESET_PC;
            imem_req    <= 1'b1;
            PC_ID       <= '0;
            inst_ID     <= NOP_INST;
            valid_ID    <= 1'b0;
        end else begin
            // Flush kills IF/ID regardless of state; PC_ID is left as is.
            if (reg_FD_flush) begin
                inst_ID  <= NOP_INST;
                valid_ID <= 1'b0;
            end
            case (state)
                FETCH_REQ: begin
                    if (reg_FD_flush) begin
                        if (imem_ready) begin
                            pc <= branch_target_ID;
                        end else begin
                            drop_target <= branch_target_ID;
                            state       <= FETCH_DROP;
                        end
                    end else if (imem_ready) begin
                        if (advance) begin
                            PC_ID    <= pc;
                            inst_ID  <= imem_rdata;
                            valid_ID <= 1'b1;
                            pc       <= next_pc(pc);
                        end else begin
                            state    <= FETCH_HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (advance) begin
                        inst_ID  <= NOP_INST;
                        valid_ID <= 1'b0;
                    end
                end
                FETCH_HOLD: begin
                    if (reg_FD_flush) begin
                        pc       <= branch_target_ID;
                        state    <= FETCH_REQ;
                        imem_req <= 1'b1;
                    end else if (advance && skid_full) begin
                        PC_ID    <= skid_addr;
                        inst_ID  <= skid_inst;
                        valid_ID <= 1'b1;
                        pc       <= next_pc(pc);
                        state    <= FETCH_REQ;
                        imem_req <= 1'b1;
                    end
                end
                FETCH_DROP: begin
                    // A stale response arriving with a new flush still retires
                    // the in-flight request, so go straight to the new target.
                    if (reg_FD_flush) begin
                        drop_target <= branch_target_ID;
                        if (imem_ready) begin
                            pc    <= branch_target_ID;
                            state <= FETCH_REQ;
                        end
                    end else begin
                        if (imem_ready) begin
                            pc    <= drop_target;
                            state <= FETCH_REQ;
                        end
                        if (advance) begin
                            inst_ID  <= NOP_INST;
                            valid_ID <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= FETCH_REQ;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_load;

    assign fetch_load = ~reg_FD_flush & advance &
                        (((state == FETCH_REQ) & imem_ready) | (state == FETCH_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == FETCH_HOLD) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of per-cycle vectors plus
// hand-written reset sequences, with a scoreboard of expected IF/ID words.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush;
    logic [31:0] branch_target_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC_ID, inst_ID;
    logic        valid_ID;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .rst              (rst),
        .PC_EN_IF         (PC_EN_IF),
        .reg_FD_EN        (reg_FD_EN),
        .reg_FD_stall     (reg_FD_stall),
        .reg_FD_flush     (reg_FD_flush),
        .branch_target_ID (branch_target_ID),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .PC_ID            (PC_ID),
        .inst_ID          (inst_ID),
        .valid_ID         (valid_ID)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, pcen, fden, stall, flush;
        logic [31:0] tgt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
        logic        push, pop;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[7:0], a[15:8], a[23:16], a[31:24]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rdy, input logic pcen, input logic fden,
                                input logic stall, input logic flush, input logic [31:0] tgt,
                                input logic ereq, input logic [31:0] eaddr, input logic evld,
                                input logic [31:0] epc, input logic push, input logic pop);
        vec_t v;
        v.rdy = rdy; v.pcen = pcen; v.fden = fden; v.stall = stall; v.flush = flush;
        v.tgt = tgt; v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
        v.push = push; v.pop = pop;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rdy, input logic pcen, input logic fden, input logic stall,
                         input logic flush, input logic [31:0] tgt, input logic [31:0] rdata);
        imem_ready       = rdy;
        PC_EN_IF         = pcen;
        reg_FD_EN        = fden;
        reg_FD_stall     = stall;
        reg_FD_flush     = flush;
        branch_target_ID = tgt;
        imem_rdata       = rdata;
    endtask

    initial begin
        sb_t e;
        // rdy pcen fden stall flush tgt | req addr valid PC_ID | push pop
        add(1,1,1,0,0,0,            1,32'h100,0,32'h000,          1,0);
        add(1,1,1,0,0,0,            1,32'h104,1,32'h100,          1,1);
        add(1,1,1,0,0,0,            1,32'h108,1,32'h104,          1,1);
        add(1,1,1,1,0,0,            1,32'h10C,1,32'h108,          1,1);
        add(0,1,1,1,0,0,            0,32'h10C,1,32'h108,          0,0);
        add(0,1,1,1,0,0,            0,32'h10C,1,32'h108,          0,0);
        add(0,1,1,0,0,0,            0,32'h10C,1,32'h108,          0,0);
        add(0,1,1,0,0,0,            1,32'h110,1,32'h10C,          0,1);
        add(0,1,1,1,0,0,            1,32'h110,0,32'h10C,          0,0);
        add(1,1,1,0,0,0,            1,32'h110,0,32'h10C,          1,0);
        add(1,0,1,0,0,0,            1,32'h114,1,32'h110,          1,1);
        add(0,1,0,0,0,0,            0,32'h114,1,32'h110,          0,0);
        add(0,1,1,0,0,0,            0,32'h114,1,32'h110,          0,0);
        add(1,1,1,0,1,32'h200,      1,32'h118,1,32'h114,          0,1);
        add(1,1,1,0,0,0,            1,32'h200,0,32'h114,          1,0);
        add(0,1,1,0,1,32'h300,      1,32'h204,1,32'h200,          0,1);
        add(0,1,1,0,0,0,            1,32'h204,0,32'h200,          0,0);
        add(1,1,1,0,0,0,            1,32'h204,0,32'h200,          0,0);
        add(1,1,1,0,0,0,            1,32'h300,0,32'h200,          1,0);
        add(0,1,1,0,1,32'h400,      1,32'h304,1,32'h300,          0,1);
        add(0,1,1,0,1,32'h500,      1,32'h304,0,32'h300,          0,0);
        add(1,1,1,0,0,0,            1,32'h304,0,32'h300,          0,0);
        add(1,1,1,0,0,0,            1,32'h500,0,32'h300,          1,0);
        add(1,1,1,1,0,0,            1,32'h504,1,32'h500,          0,1);
        add(0,1,1,1,1,32'h600,      0,32'h504,1,32'h500,          0,0);
        add(1,1,1,0,0,0,            1,32'h600,0,32'h500,          1,0);
        add(1,1,1,0,1,32'hFFFF_FFFC,1,32'h604,1,32'h600,          0,1);
        add(1,1,1,0,0,0,            1,32'hFFFF_FFFC,0,32'h600,    1,0);
        add(1,1,1,1,0,0,            1,32'h000,1,32'hFFFF_FFFC,    0,1);
        add(0,1,1,1,0,0,            0,32'h000,1,32'hFFFF_FFFC,    0,0);

        rst = 1'b1;
        drive(1, 1, 1, 0, 0, 32'h0, 32'hBAD0_BAD0);
        repeat (3) @(negedge clk);
        chk("rst_req",   {31'd0, imem_req}, 32'd1);
        chk("rst_addr",  imem_addr, 32'h100);
        chk("rst_valid", {31'd0, valid_ID}, 32'd0);
        chk("rst_pc_id", PC_ID, 32'h0);
        chk("rst_inst",  inst_ID, NOP);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].ereq});
            if (vecs[i].ereq) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].eaddr);
            chk($sformatf("v%0d_valid", i), {31'd0, valid_ID}, {31'd0, vecs[i].evld});
            chk($sformatf("v%0d_pc_id", i), PC_ID, vecs[i].epc);
            if (!vecs[i].evld) chk($sformatf("v%0d_nop", i), inst_ID, NOP);
            if (vecs[i].pop) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_sb_pc", i), PC_ID, e.addr);
                    chk($sformatf("v%0d_sb_inst", i), inst_ID, e.inst);
                end
            end
            if (vecs[i].push) begin
                e.addr = vecs[i].eaddr;
                e.inst = mem(vecs[i].eaddr);
                sb.push_back(e);
            end
            drive(vecs[i].rdy, vecs[i].pcen, vecs[i].fden, vecs[i].stall, vecs[i].flush,
                  vecs[i].tgt, vecs[i].rdy ? mem(vecs[i].eaddr) : 32'hDEAD_BEEF);
        end

        // Asynchronous reset in the middle of HOLD, away from any clock edge.
        @(negedge clk);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        drive(1, 1, 1, 0, 0, 32'h0, 32'h1234_5678);
        #2 rst = 1'b1;
        #1;
        chk("arst_req",   {31'd0, imem_req}, 32'd1);
        chk("arst_addr",  imem_addr, 32'h100);
        chk("arst_valid", {31'd0, valid_ID}, 32'd0);
        chk("arst_pc_id", PC_ID, 32'h0);
        chk("arst_inst",  inst_ID, NOP);
`ifdef FETCH_PERF_EN
        chk("arst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("arst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 1, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_req",   {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr",  imem_addr, 32'h100);
        chk("post_rst_valid", {31'd0, valid_ID}, 32'd0);
        drive(1, 1, 1, 0, 0, 32'h0, mem(32'h100));
        @(negedge clk);
        chk("post_rst_pc_id", PC_ID, 32'h100);
        chk("post_rst_inst",  inst_ID, mem(32'h100));
        chk("post_rst_addr2", imem_addr, 32'h104);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
